// File: rtl/datamemory_lsu.sv
// ============================================================================
// Module   : datamemory_lsu
// Purpose  : Byte-enabled RV32 data memory with req/ready handshake,
//            configurable read latency and misaligned/illegal access faults.
// Revision : 1.0
// ============================================================================
`default_nettype none

module datamemory_lsu #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] wd,
    input  logic [2:0]        Funct3,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rd,
    output logic              done,
    output logic              fault
);

    localparam int c_DEPTH = 1 << (ADDR_W - 2);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RD_WAIT = 2'd1;
    localparam logic [1:0] c_RESP    = 2'd2;

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("datamemory_lsu: DATA_W must be 32");
        end
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("datamemory_lsu: RD_LAT must be in 1..4");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic [1:0]        r_state;
    logic [1:0]        r_cnt;
    logic              r_rvalid;
    logic              r_done;
    logic              r_fault;
    logic [DATA_W-1:0] r_rd;
    logic [ADDR_W-3:0] r_idx;
    logic [1:0]        r_off;
    logic [2:0]        r_f3;

    logic              w_acc;
    logic              w_legal;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-3:0] w_idx;
    logic [1:0]        w_off;
    logic [2:0]        w_f3;
    logic [DATA_W-1:0] w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_ldata;

    assign ready  = (r_state != c_RD_WAIT);
    assign rvalid = r_rvalid;
    assign done   = r_done;
    assign fault  = r_fault;
    assign rd     = r_rd;

    assign w_acc = req & ready & ~reset;

    // Sub-word store data is replicated across lanes; the byte enables pick the lane.
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = '0;
        case (Funct3)
            3'b000: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << a[1:0];
                w_wdata = {4{wd[7:0]}};
            end
            3'b001: begin
                w_legal = ~a[0];
                w_be    = a[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wd[15:0]}};
            end
            3'b010: begin
                w_legal = (a[1:0] == 2'b00);
                w_be    = 4'b1111;
                w_wdata = wd;
            end
            3'b100, 3'b101: begin
                w_legal = ~MemWrite & (~Funct3[0] | ~a[0]);
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_acc && MemWrite && w_legal) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[a[ADDR_W-1:2]][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    // While waiting, the captured request addresses the array; otherwise the live one does.
    assign w_idx  = (r_state == c_RD_WAIT) ? r_idx : a[ADDR_W-1:2];
    assign w_off  = (r_state == c_RD_WAIT) ? r_off : a[1:0];
    assign w_f3   = (r_state == c_RD_WAIT) ? r_f3  : Funct3;
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_off, 3'b000} +: 8];
    assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_ldata = w_word;
        case (w_f3[1:0])
            2'b00:   w_ldata = {{24{w_byte[7] & ~w_f3[2]}}, w_byte};
            2'b01:   w_ldata = {{16{w_half[15] & ~w_f3[2]}}, w_half};
            default: w_ldata = w_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= 2'd0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
            r_rd     <= '0;
        end else begin
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
            case (r_state)
                c_RD_WAIT: begin
                    // Counter reaching zero on this edge means RESP starts next cycle.
                    if (r_cnt == 2'd1) begin
                        r_state  <= c_RESP;
                        r_cnt    <= 2'd0;
                        r_rvalid <= 1'b1;
                        r_rd     <= w_ldata;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    if (w_acc) begin
                        if (!w_legal) begin
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                        end else if (MemWrite) begin
                            r_done <= 1'b1;
                        end else if (RD_LAT == 1) begin
                            r_state  <= c_RESP;
                            r_rvalid <= 1'b1;
                            r_rd     <= w_ldata;
                        end else begin
                            r_state <= c_RD_WAIT;
                            r_cnt   <= 2'(RD_LAT - 1);
                            r_idx   <= a[ADDR_W-1:2];
                            r_off   <= a[1:0];
                            r_f3    <= Funct3;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_datamemory_lsu.sv
// ============================================================================
// Module   : tb_datamemory_lsu
// Purpose  : Scoreboard bench for datamemory_lsu at read latencies 1, 3 and 4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_datamemory_lsu;

    localparam int c_LOAD  = 0;
    localparam int c_STORE = 1;
    localparam int c_FAULT = 2;

    typedef struct {
        int          dut;
        logic        rv;
        logic        dn;
        logic        ft;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_s  [3];
    logic        req_s  [3];
    logic        mw_s   [3];
    logic [8:0]  addr_s [3];
    logic [31:0] wd_s   [3];
    logic [2:0]  f3_s   [3];
    logic        rdy_s  [3];
    logic        rv_s   [3];
    logic [31:0] rd_s   [3];
    logic        dn_s   [3];
    logic        ft_s   [3];

    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    exp_t        sb[$];
    logic [31:0] last_rd [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    datamemory_lsu #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1)) u_lat1 (
        .clk(clk), .reset(rst_s[0]), .req(req_s[0]), .MemWrite(mw_s[0]), .a(addr_s[0]),
        .wd(wd_s[0]), .Funct3(f3_s[0]), .ready(rdy_s[0]), .rvalid(rv_s[0]), .rd(rd_s[0]),
        .done(dn_s[0]), .fault(ft_s[0]));

    datamemory_lsu #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3)) u_lat3 (
        .clk(clk), .reset(rst_s[1]), .req(req_s[1]), .MemWrite(mw_s[1]), .a(addr_s[1]),
        .wd(wd_s[1]), .Funct3(f3_s[1]), .ready(rdy_s[1]), .rvalid(rv_s[1]), .rd(rd_s[1]),
        .done(dn_s[1]), .fault(ft_s[1]));

    datamemory_lsu #(.ADDR_W(9), .DATA_W(32), .RD_LAT(4)) u_lat4 (
        .clk(clk), .reset(rst_s[2]), .req(req_s[2]), .MemWrite(mw_s[2]), .a(addr_s[2]),
        .wd(wd_s[2]), .Funct3(f3_s[2]), .ready(rdy_s[2]), .rvalid(rv_s[2]), .rd(rd_s[2]),
        .done(dn_s[2]), .fault(ft_s[2]));

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input int i, input int kind, input logic [31:0] ld, input int due);
        exp_t e;
        e.dut  = i;
        e.rv   = (kind == c_LOAD);
        e.dn   = (kind != c_LOAD);
        e.ft   = (kind == c_FAULT);
        e.data = ld;
        e.cyc  = due;
        return e;
    endfunction

    // Drive one request at a negedge, record its expected retire, return after the accept edge.
    task automatic issue(input int i, input logic we, input logic [2:0] f3, input logic [8:0] ad,
                         input logic [31:0] d, input int kind, input logic [31:0] ld);
        @(negedge clk);
        req_s[i]  = 1'b1;
        mw_s[i]   = we;
        f3_s[i]   = f3;
        addr_s[i] = ad;
        wd_s[i]   = d;
        check($sformatf("ready_before_accept_dut%0d_a%h", i, ad), 69'(rdy_s[i]), 69'(1));
        if (kind == c_LOAD) begin
            last_rd[i] = ld;
            sb.push_back(mk(i, kind, ld, cyc + lat_of(i)));
        end else begin
            sb.push_back(mk(i, kind, last_rd[i], cyc + 1));
        end
        @(posedge clk);
    endtask

    task automatic idle(input int i, input int n);
        @(negedge clk);
        req_s[i] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Retire monitor: every rvalid/done pulse must match the oldest expectation exactly.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check($sformatf("missing_pulse_dut%0d_due%0d", sb[0].dut, sb[0].cyc), 69'(0), 69'(1));
            void'(sb.pop_front());
        end
        for (int i = 0; i < 3; i++) begin
            if (rv_s[i] === 1'b1 || dn_s[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    check($sformatf("unexpected_pulse_dut%0d", i), 69'({rv_s[i], dn_s[i]}), 69'(0));
                end else begin
                    e = sb.pop_front();
                    check($sformatf("retire_dut%0d_cyc%0d", i, cyc),
                          {2'(i), rv_s[i], dn_s[i], ft_s[i], rd_s[i], 32'(cyc)},
                          {2'(e.dut), e.rv, e.dn, e.ft, e.data, 32'(e.cyc)});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1; req_s[i] = 1'b0; mw_s[i] = 1'b0;
            addr_s[i] = '0; wd_s[i] = '0; f3_s[i] = 3'b010; last_rd[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_state_dut%0d", i),
                  69'({rdy_s[i], rv_s[i], dn_s[i], ft_s[i], rd_s[i]}),
                  69'({1'b1, 3'b000, 32'h0}));
            rst_s[i] = 1'b0;
        end

        // RD_LAT=1: word round trip, load straight after store.
        issue(0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, c_STORE, 32'h0);
        issue(0, 1'b0, 3'b010, 9'h010, 32'h0,        c_LOAD,  32'hDEADBEEF);
        idle(0, 2);

        // Byte lanes and sign/zero extension.
        issue(0, 1'b1, 3'b010, 9'h020, 32'h00000000, c_STORE, 32'h0);
        issue(0, 1'b1, 3'b000, 9'h023, 32'h00000080, c_STORE, 32'h0);
        issue(0, 1'b1, 3'b001, 9'h020, 32'h00001234, c_STORE, 32'h0);
        issue(0, 1'b0, 3'b010, 9'h020, 32'h0, c_LOAD, 32'h80001234);
        issue(0, 1'b0, 3'b000, 9'h023, 32'h0, c_LOAD, 32'hFFFFFF80);
        issue(0, 1'b0, 3'b100, 9'h023, 32'h0, c_LOAD, 32'h00000080);
        issue(0, 1'b0, 3'b001, 9'h022, 32'h0, c_LOAD, 32'hFFFF8000);
        issue(0, 1'b0, 3'b101, 9'h022, 32'h0, c_LOAD, 32'h00008000);
        idle(0, 2);

        // Faults: misaligned LW, misaligned SH, illegal funct3, store with load-only funct3.
        issue(0, 1'b0, 3'b010, 9'h011, 32'h0,        c_FAULT, 32'h0);
        issue(0, 1'b1, 3'b001, 9'h021, 32'hFFFFFFFF, c_FAULT, 32'h0);
        issue(0, 1'b0, 3'b011, 9'h010, 32'h0,        c_FAULT, 32'h0);
        issue(0, 1'b1, 3'b100, 9'h010, 32'h00000000, c_FAULT, 32'h0);
        issue(0, 1'b0, 3'b010, 9'h010, 32'h0,        c_LOAD,  32'hDEADBEEF);
        issue(0, 1'b0, 3'b010, 9'h020, 32'h0,        c_LOAD,  32'h80001234);
        idle(0, 2);

        // Back-to-back byte stores, one per cycle.
        issue(0, 1'b1, 3'b000, 9'h030, 32'h00000011, c_STORE, 32'h0);
        issue(0, 1'b1, 3'b000, 9'h031, 32'h00000022, c_STORE, 32'h0);
        issue(0, 1'b1, 3'b000, 9'h032, 32'h00000033, c_STORE, 32'h0);
        issue(0, 1'b1, 3'b000, 9'h033, 32'h00000044, c_STORE, 32'h0);
        issue(0, 1'b0, 3'b010, 9'h030, 32'h0,        c_LOAD,  32'h44332211);
        idle(0, 3);

        // RD_LAT=3 with req held high for 8 cycles: accepts land in IDLE and RESP cycles.
        issue(1, 1'b1, 3'b010, 9'h040, 32'hCAFEF00D, c_STORE, 32'h0);
        pat = 8'b0100_1001;
        @(negedge clk);
        req_s[1] = 1'b1; mw_s[1] = 1'b0; f3_s[1] = 3'b010; addr_s[1] = 9'h040;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("lat3_ready_k%0d", k), 69'(rdy_s[1]), 69'(pat[k]));
            if (pat[k]) begin
                last_rd[1] = 32'hCAFEF00D;
                sb.push_back(mk(1, c_LOAD, 32'hCAFEF00D, cyc + 3));
            end
        end
        idle(1, 4);

        // RD_LAT=4: reset two cycles after a load accept drops that load, keeps memory.
        issue(2, 1'b1, 3'b010, 9'h050, 32'h5A5AA5A5, c_STORE, 32'h0);
        issue(2, 1'b0, 3'b010, 9'h050, 32'h0,        c_LOAD,  32'h5A5AA5A5);
        idle(2, 5);
        issue(2, 1'b0, 3'b000, 9'h050, 32'h0,        c_LOAD,  32'hFFFFFFA5);
        @(negedge clk);
        req_s[2] = 1'b0;
        @(negedge clk);
        rst_s[2] = 1'b1;
        sb.delete();
        last_rd[2] = '0;
        @(negedge clk);
        rst_s[2] = 1'b0;
        check("lat4_after_reset", 69'({rdy_s[2], rv_s[2], rd_s[2]}), 69'({1'b1, 1'b0, 32'h0}));
        repeat (6) @(negedge clk);
        issue(2, 1'b0, 3'b010, 9'h050, 32'h0, c_LOAD, 32'h5A5AA5A5);
        idle(2, 8);

        check("scoreboard_drained", 69'(sb.size()), 69'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/datamemory_lsu.md
# datamemory_lsu

Parametrised, handshaked RV32 data memory for the single-clock core. It replaces the combinational data-memory wrapper with an owned, byte-enabled word array behind a request/response protocol. The protocol has configurable read latency and supports all RV32I loads/stores: LB, LH, LW, LBU, LHU, SB, SH, SW. Misaligned or illegal accesses are flagged instead of returning X. It sits between the EX/MEM stage (address from the ALU, funct3 from instruction bits 14:12) and the writeback mux, and stalls the pipeline through `ready`.

## Interface
- `ADDR_W`, 9: byte-address width. Array depth is 2^(ADDR_W-2) words.
- `DATA_W`, 32: data width. Only 32 is supported; other values are an elaboration error.
- `RD_LAT`, 1: read latency in cycles, legal range 1..4. Other values are an elaboration error.
- `clk` input, 1: the single clock. All state updates on its rising edge.
- `reset` input, 1: synchronous, active-high.
- `req` input, 1: access request. Sampled only when `ready`=1.
- `MemWrite` input, 1: 1 = store, 0 = load. Qualified by `req`.
- `a` input, ADDR_W: byte address.
- `wd` input, DATA_W: store data. Low byte/half is used for SB/SH.
- `Funct3` input, 3: access size/sign.
- `ready` output, 1: request can be accepted this cycle.
- `rvalid` output, 1: one-cycle pulse; `rd` holds load data.
- `rd` output, DATA_W: load result. Holds its value between pulses.
- `done` output, 1: one-cycle pulse; store retired or faulted access retired.
- `fault` output, 1: one-cycle pulse coincident with the retire pulse of a misaligned/illegal access.

## Operation
- Accept: an access is accepted at a rising edge where `req`=1 and `ready`=1. Inputs are captured at that edge.
- Word index is `a[ADDR_W-1:2]`; byte offset is `a[1:0]`.
- Legal Funct3 values:
  - 000 LB/SB: any offset.
  - 001 LH/SH: offset 00 or 10.
  - 010 LW/SW: offset 00.
  - 100 LBU: any offset.
  - 101 LHU: offset 00 or 10.
  - Stores with 100/101 are illegal. Funct3 011/110/111 are illegal.
- Fault: illegal or misaligned access. No array access or update. `done`=1 and `fault`=1 the next cycle; `rvalid` stays 0; `rd` is unchanged.
- Store: byte enables:
  - SB: bit `1<<a[1:0]`.
  - SH: 0011 (offset 00) or 1100 (offset 10).
  - SW: 1111.
  - `wd` is lane-shifted to the addressed byte/half. Untouched bytes keep their contents.
- Load extraction:
  - LB/LBU: byte `a[1:0]`, sign- or zero-extended to 32.
  - LH/LHU: half `a[1]`, sign- or zero-extended to 32.
  - LW: full word.
- FSM has three states:
  - IDLE: `ready`=1.
    - Accepted load goes to RD_WAIT with counter=RD_LAT-1.
    - Accepted store or fault stays in IDLE; the retire pulse comes next cycle.
  - RD_WAIT: `ready`=0. Counter decrements each cycle. At 0, go to RESP.
    - When RD_LAT=1, RD_WAIT is skipped and the load goes directly to RESP.
  - RESP: `rvalid`=1 and `rd` is updated (one cycle). `ready`=1 in this cycle, so a new request may be accepted here. Next state is IDLE, or the accepted request's path.
- Array contents are not reset. A simulation `$readmemh` hook is optional.

## Timing
- Reset values: `ready`=1, `rvalid`=0, `done`=0, `fault`=0, `rd`=0. FSM goes to IDLE and the counter to 0.
- Load latency: accept at edge T means `rvalid` is high during cycle T+RD_LAT (RD_LAT=1 means the cycle right after acceptance).
- Load throughput: one load per RD_LAT cycles (back-to-back accept in RESP).
- Store latency: array updated at accept edge T; `done` high in cycle T+1. `ready` stays 1, so stores sustain one per cycle.
- Read-after-write: a load accepted at edge T+1 after a store at T to the same word returns the new bytes.
- Load directly after store: the load accept edge coincides with the store's `done` cycle; this is legal.
- Reset mid-load: the pending load is dropped; `rvalid` never pulses for it. Stores already accepted remain written.
- `rvalid` and `done` are never high together for the same access. A fault pulses only `done`+`fault`.
- `req`=1 while `ready`=0 is ignored. The master must hold or re-present the request; the block does not queue it.

## Test plan
- Word round trip: RD_LAT=1. SW 0xDEADBEEF @0x010, then LW @0x010. Required: `done` one cycle after the store; `rvalid` one cycle after the load accept with `rd`=0xDEADBEEF.
- Byte lanes: SW 0x00000000 @0x020, then SB 0x80 @0x023 and SH 0x1234 @0x020. Required:
  - LW @0x020 → 0x80001234.
  - LB @0x023 → 0xFFFFFF80; LBU @0x023 → 0x00000080.
  - LH @0x022 → 0xFFFF8000; LHU @0x022 → 0x00008000.
- Faults: LW @0x011, SH @0x021, Funct3=011. Required for each: `done`=`fault`=1 for one cycle, `rvalid`=0, and a following LW @0x010 is unchanged.
- Latency/backpressure: RD_LAT=3. Present LW with `req` held high for 8 cycles. Required: `ready`=0 for the 2 cycles after accept, `rvalid` at accept+3, and a second accept in the RESP cycle.
- Reset mid-load: RD_LAT=4. Assert `reset` 2 cycles after a load accept. Required: no `rvalid`, `ready`=1 and `rd`=0 after reset, and memory keeps prior stores.
- Back-to-back stores: 4 consecutive SB @0x030..0x033 (0x11, 0x22, 0x33, 0x44), one per cycle. Required: 4 consecutive `done` pulses, then LW @0x030 → 0x44332211.
